// File: rtl/core_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a small
// circular return-address stack. Lookup is combinational; all updates are on the rising edge of clk.
module core_btb #(
  parameter int         ENTRIES   = 16,
  parameter int         RAS_DEPTH = 4,
  parameter logic [1:0] br_type   = 2'b00,
  parameter logic [1:0] j_type    = 2'b01,
  parameter logic [1:0] jal_type  = 2'b10,
  parameter logic [1:0] jr_type   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_go,
  input  logic        update_v,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic [1:0]  update_type,
  input  logic        update_taken,
  input  logic        update_kill,
  output logic        btb_v,
  output logic [1:0]  btb_type,
  output logic [31:0] btb_target,
  output logic [31:0] ras_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] TOP_LAST = PW'(RAS_DEPTH - 1);

  logic          r_valid  [ENTRIES];
  logic [25:0]   r_tag    [ENTRIES];
  logic [1:0]    r_type   [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];
  logic [31:0]   r_target [ENTRIES];
  logic [31:0]   r_stack  [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_cnt;

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_u_idx;
  logic          w_hit;
  logic          w_u_match;
  logic          w_ras_nonempty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;
  logic          w_unused;

  assign w_unused = &{1'b0, pc_in[1:0], update_pc[1:0]};

  assign w_idx          = pc_in[2 +: IW];
  assign w_u_idx        = update_pc[2 +: IW];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == pc_in[31:6]);
  assign w_u_match      = r_valid[w_u_idx] && (r_tag[w_u_idx] == update_pc[31:6]);
  assign w_ras_nonempty = (r_cnt != '0);

  assign w_push    = pc_go && w_hit && (r_type[w_idx] == jal_type);
  assign w_pop     = pc_go && w_hit && (r_type[w_idx] == jr_type) && w_ras_nonempty;
  assign w_top_inc = (r_top == TOP_LAST) ? '0 : r_top + 1'b1;
  assign w_top_dec = (r_top == '0) ? TOP_LAST : r_top - 1'b1;

  assign ras_target = w_ras_nonempty ? r_stack[r_top] : 32'h0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    btb_v      = 1'b0;
    btb_type   = 2'b00;
    btb_target = 32'h0;
    if (w_hit) begin
      btb_type   = r_type[w_idx];
      btb_target = r_target[w_idx];
      unique case (r_type[w_idx])
        j_type, jal_type: btb_v = 1'b1;
        br_type:          btb_v = r_ctr[w_idx][1];
        default:          btb_v = w_ras_nonempty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table and stack are reset explicitly because lookups must read zeros after reset.
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_type[i]   <= 2'b00;
        r_ctr[i]    <= 2'b00;
        r_target[i] <= 32'h0;
      end
      for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= 32'h0;
      r_top <= '0;
      r_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so same-cycle lookups see the pre-update contents.
      // Kill and update always share an index, so kill simply takes priority.
      if (update_kill) begin
        r_valid[w_u_idx] <= 1'b0;
      end else if (update_v) begin
        if (w_u_match) begin
          r_type[w_u_idx]   <= update_type;
          r_target[w_u_idx] <= update_target;
          if (update_type == br_type) begin
            if (update_taken && r_ctr[w_u_idx] != 2'b11)
              r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'b01;
            else if (!update_taken && r_ctr[w_u_idx] != 2'b00)
              r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'b01;
          end
        end else if (update_type != br_type || update_taken) begin
          r_valid[w_u_idx]  <= 1'b1;
          r_tag[w_u_idx]    <= update_pc[31:6];
          r_type[w_u_idx]   <= update_type;
          r_target[w_u_idx] <= update_target;
          if (update_type == br_type) r_ctr[w_u_idx] <= 2'b10;
        end
      end

      if (w_push) begin
        r_stack[w_top_inc] <= pc_in + 32'd4;
        r_top              <= w_top_inc;
        if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_top <= w_top_dec;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_btb.sv
// Directed testbench for core_btb: hand-computed expectations for lookup,
// counter training, kill priority, RAS push/pop/wrap and synchronous reset.
module tb_core_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_go;
  logic        update_v;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic [1:0]  update_type;
  logic        update_taken;
  logic        update_kill;
  logic        btb_v;
  logic [1:0]  btb_type;
  logic [31:0] btb_target;
  logic [31:0] ras_target;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] RA_A = 32'h0004_0024;
  localparam logic [31:0] RA_B = 32'h0004_0044;

  core_btb dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pc_go        (pc_go),
    .update_v     (update_v),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_type  (update_type),
    .update_taken (update_taken),
    .update_kill  (update_kill),
    .btb_v        (btb_v),
    .btb_type     (btb_type),
    .btb_target   (btb_target),
    .ras_target   (ras_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Advance one rising edge; inputs change 1ns after it, checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] ty,
                     input logic [31:0] tgt, input logic tk);
    update_v      = 1'b1;
    update_pc     = pc;
    update_type   = ty;
    update_target = tgt;
    update_taken  = tk;
    tick();
    update_v = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic v,
                      input logic [1:0] ty, input logic [31:0] tgt);
    pc_in = pc;
    #1;
    check({tag, ".v"}, 32'(btb_v), 32'(v));
    check({tag, ".type"}, 32'(btb_type), 32'(ty));
    check({tag, ".tgt"}, btb_target, tgt);
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h0; pc_go = 1'b0;
    update_v = 1'b0; update_pc = 32'h0; update_target = 32'h0;
    update_type = 2'b00; update_taken = 1'b0; update_kill = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    look("rst", 32'h0004_0000, 1'b0, 2'b00, 32'h0);
    check("rst.ras", ras_target, 32'h0);

    // Jump allocation; same-cycle lookup sees the old (empty) entry
    pc_in = 32'h0004_0008;
    update_v = 1'b1; update_pc = 32'h0004_0008; update_type = 2'b01;
    update_target = 32'h0004_0100; update_taken = 1'b0;
    #1;
    check("j.pre.v", 32'(btb_v), 32'd0);
    tick();
    update_v = 1'b0;
    look("j.hit", 32'h0004_0008, 1'b1, 2'b01, 32'h0004_0100);
    look("j.alias", 32'h0004_0048, 1'b0, 2'b00, 32'h0);

    // Branch counter training at 0x40010
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b1);
    look("br.10", 32'h0004_0010, 1'b1, 2'b00, 32'h0004_0200);
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b0);
    look("br.01", 32'h0004_0010, 1'b0, 2'b00, 32'h0004_0200);
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b1);
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b1);
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b0);
    look("br.11to10", 32'h0004_0010, 1'b1, 2'b00, 32'h0004_0200);
    upd(32'h0004_0010, 2'b00, 32'h0004_0200, 1'b0);
    look("br.01b", 32'h0004_0010, 1'b0, 2'b00, 32'h0004_0200);

    // Not-taken branch miss does not allocate
    upd(32'h0004_0014, 2'b00, 32'h0004_0300, 1'b0);
    look("br.nalloc", 32'h0004_0014, 1'b0, 2'b00, 32'h0);

    // Kill beats a simultaneous update; same-cycle lookup sees old entry
    pc_in = 32'h0004_0008;
    update_v = 1'b1; update_kill = 1'b1; update_pc = 32'h0004_0008;
    update_type = 2'b01; update_target = 32'h0004_0300;
    #1;
    check("kill.pre.tgt", btb_target, 32'h0004_0100);
    tick();
    update_v = 1'b0; update_kill = 1'b0;
    look("kill.post", 32'h0004_0008, 1'b0, 2'b00, 32'h0);

    // RAS: jal at 0x40020, jr at 0x40030, second jal at 0x40040
    upd(32'h0004_0020, 2'b10, 32'h0004_0800, 1'b0);
    upd(32'h0004_0030, 2'b11, 32'h0000_0000, 1'b0);
    upd(32'h0004_0040, 2'b10, 32'h0004_0900, 1'b0);
    look("jr.empty", 32'h0004_0030, 1'b0, 2'b11, 32'h0);
    look("jal.hit", 32'h0004_0020, 1'b1, 2'b10, 32'h0004_0800);

    pc_go = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pc_go = 1'b0;
    #1;
    check("ras.full", ras_target, RA_A);

    pc_in = 32'h0004_0030;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("pop%0d.v", i), 32'(btb_v), 32'd1);
      pc_go = 1'b1;
      tick();
      pc_go = 1'b0;
    end
    #1;
    check("pop.empty.v", 32'(btb_v), 32'd0);
    check("pop.empty.ras", ras_target, 32'h0);
    pc_go = 1'b1;
    tick();
    pc_go = 1'b0;
    #1;
    check("pop5.ras", ras_target, 32'h0);
    check("pop5.v", 32'(btb_v), 32'd0);

    // Wrap: push A,B,A,B,A onto a depth-4 stack, then pop in LIFO order
    for (int i = 0; i < 5; i++) begin
      pc_in = (i % 2 == 0) ? 32'h0004_0020 : 32'h0004_0040;
      pc_go = 1'b1;
      tick();
    end
    pc_go = 1'b0;
    #1;
    check("wrap.top", ras_target, RA_A);

    // pc_go low: jal hit does not push
    pc_in = 32'h0004_0040;
    tick();
    check("nogo.ras", ras_target, RA_A);

    // Pop concurrent with an unrelated BTB update
    pc_in = 32'h0004_0030; pc_go = 1'b1;
    upd(32'h0004_0050, 2'b01, 32'h0004_0500, 1'b0);
    pc_go = 1'b0;
    #1;
    check("pop+upd.ras", ras_target, RA_B);
    look("pop+upd.btb", 32'h0004_0050, 1'b1, 2'b01, 32'h0004_0500);
    pc_in = 32'h0004_0030; pc_go = 1'b1;
    tick();
    pc_go = 1'b0;
    #1;
    check("wrap.pop2", ras_target, RA_A);

    // Reset overrides a concurrent update and push
    rst = 1'b1; pc_in = 32'h0004_0020; pc_go = 1'b1;
    upd(32'h0004_0060, 2'b01, 32'h0004_0600, 1'b0);
    rst = 1'b0; pc_go = 1'b0;
    look("rst2.jal", 32'h0004_0020, 1'b0, 2'b00, 32'h0);
    look("rst2.upd", 32'h0004_0060, 1'b0, 2'b00, 32'h0);
    look("rst2.br", 32'h0004_0010, 1'b0, 2'b00, 32'h0);
    check("rst2.ras", ras_target, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
